bram_wr_ctrl: RTL and testbench

BRAM_WR_CTRL -- requirements
Module: bram_wr_ctrl

---
 rtl/bram_wr_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_bram_wr_ctrl.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_wr_ctrl.sv
// bram_wr_ctrl: buffers filter result words in a small FIFO and writes them
// one at a time to a BRAM port using a trig/done handshake with timeout abort.
module bram_wr_ctrl #(
   parameter int unsigned FIFO_DEPTH = 4,    // power of two, >= 2
   parameter int unsigned TIMEOUT    = 255   // 1..65535 cycles
) (
   input  logic        i_clk,
   input  logic        i_rstn,
   input  logic        i_start,
   input  logic [12:0] i_base_addr,
   input  logic [31:0] i_data,
   input  logic        i_valid,
   output logic        o_ready,
   output logic [12:0] o_bram_addr,
   output logic [31:0] o_bram_data,
   output logic        o_bram_trig,
   input  logic        i_bram_done,
   output logic        o_busy,
   output logic [13:0] o_wr_cnt,
   output logic        o_err
);

   localparam int unsigned ADDR_W = 13;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned WCNT_W = 14;
   localparam int unsigned TMO_W  = 16;
   localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned OCC_W  = PTR_W + 1;

   localparam logic [WCNT_W-1:0] WCNT_MAX = '1;
   localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT - 1);
   localparam logic [OCC_W-1:0]  OCC_FULL = OCC_W'(FIFO_DEPTH);

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_WRITE = 1'b1
   } state_t;

   // FIFO storage and bookkeeping
   logic [DATA_W-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [OCC_W-1:0]  occ;
   logic              fifo_full;
   logic              fifo_empty;
   logic              push_c;
   logic              pop_c;

   // Controller state
   state_t            state_q;
   state_t            state_d;
   logic [ADDR_W-1:0] addr_q;
   logic [ADDR_W-1:0] addr_d;
   logic [TMO_W-1:0]  tmo_q;
   logic [TMO_W-1:0]  tmo_d;
   logic              trig_d;
   logic [ADDR_W-1:0] bram_addr_d;
   logic [DATA_W-1:0] bram_data_d;
   logic [WCNT_W-1:0] wr_cnt_d;
   logic              err_d;
   logic              start_ok;

   // Flags come from registered occupancy only, so a pop never frees a slot
   // for a push within the same cycle.
   assign fifo_full  = (occ == OCC_FULL);
   assign fifo_empty = (occ == '0);
   assign push_c     = i_valid & ~fifo_full;
   assign o_ready    = ~fifo_full;
   assign o_busy     = (state_q == ST_WRITE) | ~fifo_empty;
   assign start_ok   = i_start & ~o_busy;

   // FIFO data array; contents need no reset since pointers define validity
   always_ff @(posedge i_clk) begin
      if (push_c) begin
         mem[wr_ptr] <= i_data;
      end
   end

   // FIFO pointers and occupancy; simultaneous push and pop leave occupancy unchanged
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         occ    <= '0;
      end else begin
         if (push_c) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop_c) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({push_c, pop_c})
            2'b10:   occ <= occ + OCC_W'(1);
            2'b01:   occ <= occ - OCC_W'(1);
            default: occ <= occ;
         endcase
      end
   end

   // State and output registers
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state_q     <= ST_IDLE;
         addr_q      <= '0;
         tmo_q       <= '0;
         o_bram_trig <= 1'b0;
         o_bram_addr <= '0;
         o_bram_data <= '0;
         o_wr_cnt    <= '0;
         o_err       <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         tmo_q       <= tmo_d;
         o_bram_trig <= trig_d;
         o_bram_addr <= bram_addr_d;
         o_bram_data <= bram_data_d;
         o_wr_cnt    <= wr_cnt_d;
         o_err       <= err_d;
      end
   end

   // Next-state and output logic for the write handshake
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      tmo_d       = tmo_q;
      trig_d      = o_bram_trig;
      bram_addr_d = o_bram_addr;
      bram_data_d = o_bram_data;
      wr_cnt_d    = o_wr_cnt;
      err_d       = o_err;
      pop_c       = 1'b0;

      case (state_q)
         ST_IDLE: begin
            // Start is only honoured when idle and empty, so it never
            // competes with launching a write.
            if (start_ok) begin
               addr_d   = i_base_addr;
               wr_cnt_d = '0;
               err_d    = 1'b0;
            end else if (!fifo_empty) begin
               // Head stays in the FIFO until the write completes or aborts
               bram_data_d = mem[rd_ptr];
               bram_addr_d = addr_q;
               trig_d      = 1'b1;
               tmo_d       = '0;
               state_d     = ST_WRITE;
            end
         end

         ST_WRITE: begin
            if (i_bram_done) begin
               pop_c   = 1'b1;
               trig_d  = 1'b0;
               addr_d  = addr_q + ADDR_W'(1);
               state_d = ST_IDLE;
               if (o_wr_cnt != WCNT_MAX) begin
                  wr_cnt_d = o_wr_cnt + WCNT_W'(1);
               end
            end else if (tmo_q == TMO_LAST) begin
               // Abort: drop the word but still consume its address slot
               pop_c   = 1'b1;
               trig_d  = 1'b0;
               err_d   = 1'b1;
               addr_d  = addr_q + ADDR_W'(1);
               state_d = ST_IDLE;
            end else begin
               tmo_d = tmo_q + TMO_W'(1);
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_bram_wr_ctrl.sv
// Self-checking bench for bram_wr_ctrl: scoreboard of expected (address, data)
// writes filled on push, drained by a BRAM sink model with programmable latency.
module tb_bram_wr_ctrl;

   localparam int unsigned DEPTH = 4;

   typedef struct packed {
      logic [12:0] addr;
      logic [31:0] data;
   } exp_t;

   logic        clk;
   logic        rstn;

   // main instance (default timeout)
   logic        start;
   logic [12:0] base;
   logic [31:0] data;
   logic        valid;
   logic        done;
   logic        ready;
   logic [12:0] baddr;
   logic [31:0] bdata;
   logic        trig;
   logic        busy;
   logic [13:0] wr_cnt;
   logic        err;

   // short-timeout instance
   logic        t_start;
   logic [12:0] t_base;
   logic [31:0] t_data;
   logic        t_valid;
   logic        t_done;
   logic        t_ready;
   logic [12:0] t_baddr;
   logic [31:0] t_bdata;
   logic        t_trig;
   logic        t_busy;
   logic [13:0] t_wr_cnt;
   logic        t_err;

   int          n_tests;
   int          n_fail;
   exp_t        exp_q[$];
   logic [12:0] model_addr;
   int          sink_lat;
   int          hi_cnt;
   int          n_wr;
   int          n_rise;
   int          n_acc;
   int          first_stall_acc;
   logic [12:0] cur_addr;
   logic [31:0] cur_data;

   bram_wr_ctrl #(.FIFO_DEPTH(DEPTH), .TIMEOUT(255)) u_dut (
      .i_clk       (clk),
      .i_rstn      (rstn),
      .i_start     (start),
      .i_base_addr (base),
      .i_data      (data),
      .i_valid     (valid),
      .o_ready     (ready),
      .o_bram_addr (baddr),
      .o_bram_data (bdata),
      .o_bram_trig (trig),
      .i_bram_done (done),
      .o_busy      (busy),
      .o_wr_cnt    (wr_cnt),
      .o_err       (err)
   );

   bram_wr_ctrl #(.FIFO_DEPTH(DEPTH), .TIMEOUT(8)) u_dut_to (
      .i_clk       (clk),
      .i_rstn      (rstn),
      .i_start     (t_start),
      .i_base_addr (t_base),
      .i_data      (t_data),
      .i_valid     (t_valid),
      .o_ready     (t_ready),
      .o_bram_addr (t_baddr),
      .o_bram_data (t_bdata),
      .o_bram_trig (t_trig),
      .i_bram_done (t_done),
      .o_busy      (t_busy),
      .o_wr_cnt    (t_wr_cnt),
      .o_err       (t_err)
   );

   // 100 MHz clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop if the run never reaches its summary
   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, failed so far %0d", n_fail);
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // Sink and monitor for the main instance: answers trig after sink_lat+1
   // high cycles and checks each completed write against the scoreboard.
   initial begin
      exp_t e;
      hi_cnt = 0;
      n_wr   = 0;
      n_rise = 0;
      done   = 1'b0;
      forever begin
         @(negedge clk);
         if (!rstn) begin
            hi_cnt = 0;
            done   = 1'b0;
         end else if (trig) begin
            if (hi_cnt == 0) begin
               n_rise++;
               cur_addr = baddr;
               cur_data = bdata;
            end else begin
               check("addr_stable", 32'(baddr), 32'(cur_addr));
               check("data_stable", bdata, cur_data);
            end
            hi_cnt++;
            if (!done && hi_cnt == sink_lat + 1) begin
               done = 1'b1;
               n_wr++;
               check("write_expected", 32'(exp_q.size() != 0), 32'(1));
               if (exp_q.size() != 0) begin
                  e = exp_q.pop_front();
                  check("write_addr", 32'(baddr), 32'(e.addr));
                  check("write_data", bdata, e.data);
               end
            end
         end else begin
            if (hi_cnt > 0) begin
               check("trig_fall_on_done", 32'(done), 32'(1));
               if (done) begin
                  check("trig_high_len", 32'(hi_cnt), 32'(sink_lat + 1));
               end
            end
            hi_cnt = 0;
            done   = 1'b0;
         end
      end
   end

   // Offer one word; records its expected write once the DUT accepts it
   task automatic push_word(input logic [31:0] d);
      int guard;
      exp_t e;
      guard = 0;
      valid = 1'b1;
      data  = d;
      if (!ready && first_stall_acc < 0) begin
         first_stall_acc = n_acc;
      end
      while (!ready && guard < 500) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 500) begin
         check("push_accept_in_time", 32'(guard), 32'(0));
      end
      e.addr = model_addr;
      e.data = d;
      exp_q.push_back(e);
      model_addr = model_addr + 13'd1;
      n_acc++;
      @(negedge clk);
   endtask

   task automatic do_start(input logic [12:0] b, input bit accept);
      start = 1'b1;
      base  = b;
      if (accept) begin
         model_addr = b;
      end
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_drain();
      int g;
      g = 0;
      while ((busy || exp_q.size() != 0) && g < 3000) begin
         @(negedge clk);
         g++;
      end
      check("drain_in_time", 32'(g < 3000), 32'(1));
   endtask

   // Returns number of negedges waited; gives up after limit
   task automatic wait_t_trig(input logic level, output int g);
      g = 0;
      while (t_trig != level && g < 50) begin
         @(negedge clk);
         g++;
      end
      check("t_trig_wait", 32'(g < 50), 32'(1));
   endtask

   initial begin
      int g;
      int hi;
      int w0;
      int r0;
      n_tests = 0;
      n_fail  = 0;
      rstn = 1'b0;
      start = 1'b0; base = '0; data = '0; valid = 1'b0;
      t_start = 1'b0; t_base = '0; t_data = '0; t_valid = 1'b0; t_done = 1'b0;
      sink_lat = 0;
      model_addr = '0;
      n_acc = 0;
      first_stall_acc = -1;

      // reset values
      repeat (3) @(negedge clk);
      check("rst_ready",  32'(ready),  32'(1));
      check("rst_busy",   32'(busy),   32'(0));
      check("rst_trig",   32'(trig),   32'(0));
      check("rst_addr",   32'(baddr),  32'(0));
      check("rst_data",   bdata,       32'(0));
      check("rst_wr_cnt", 32'(wr_cnt), 32'(0));
      check("rst_err",    32'(err),    32'(0));
      check("rst_t_ready", 32'(t_ready), 32'(1));
      check("rst_t_busy",  32'(t_busy),  32'(0));
      rstn = 1'b1;
      @(negedge clk);

      // timeout: trig held exactly 8 cycles, error set, next word uses next address
      t_start = 1'b1; t_base = 13'h020;
      @(negedge clk);
      t_start = 1'b0; t_valid = 1'b1; t_data = 32'hC0DE_0001;
      @(negedge clk);
      t_data = 32'hC0DE_0002;
      @(negedge clk);
      t_valid = 1'b0;
      wait_t_trig(1'b1, g);
      check("to_first_addr", 32'(t_baddr), 32'(13'h020));
      check("to_first_data", t_bdata, 32'hC0DE_0001);
      hi = 0;
      while (t_trig && hi < 50) begin
         hi++;
         @(negedge clk);
      end
      check("to_trig_high_cycles", 32'(hi), 32'(8));
      check("to_err_set", 32'(t_err), 32'(1));
      check("to_wr_cnt_kept", 32'(t_wr_cnt), 32'(0));
      wait_t_trig(1'b1, g);
      check("to_next_addr", 32'(t_baddr), 32'(13'h021));
      check("to_next_data", t_bdata, 32'hC0DE_0002);
      t_done = 1'b1;
      @(negedge clk);
      t_done = 1'b0;
      check("to_done_trig_low", 32'(t_trig), 32'(0));
      check("to_done_wr_cnt", 32'(t_wr_cnt), 32'(1));
      check("to_err_sticky", 32'(t_err), 32'(1));
      check("to_idle", 32'(t_busy), 32'(0));
      t_start = 1'b1; t_base = 13'h040;
      @(negedge clk);
      t_start = 1'b0;
      check("to_start_clr_err", 32'(t_err), 32'(0));
      check("to_start_clr_cnt", 32'(t_wr_cnt), 32'(0));

      // two words at 0x100, zero-latency sink
      sink_lat = 0;
      do_start(13'h100, 1'b1);
      push_word(32'hA0A0_A0A0);
      push_word(32'hB1B1_B1B1);
      valid = 1'b0;
      wait_drain();
      check("s1_wr_cnt", 32'(wr_cnt), 32'(2));
      check("s1_err", 32'(err), 32'(0));

      // address wrap 0x1FFE -> 0x0000, latency 3
      sink_lat = 3;
      do_start(13'h1FFE, 1'b1);
      push_word(32'h1111_0001);
      push_word(32'h2222_0002);
      push_word(32'h3333_0003);
      valid = 1'b0;
      wait_drain();
      check("s2_wr_cnt", 32'(wr_cnt), 32'(3));

      // back-pressure: 6 words into a 4-deep FIFO with a slow sink
      sink_lat = 10;
      do_start(13'h200, 1'b1);
      n_acc = 0;
      first_stall_acc = -1;
      for (int i = 0; i < 6; i++) begin
         push_word(32'hD000_0000 + 32'(i));
      end
      valid = 1'b0;
      check("s3_stall_after_depth", 32'(first_stall_acc), 32'(DEPTH));
      wait_drain();
      check("s3_wr_cnt", 32'(wr_cnt), 32'(6));

      // start while busy is ignored; start after drain takes effect
      do_start(13'h300, 1'b1);
      push_word(32'hE000_0000);
      push_word(32'hE000_0001);
      valid = 1'b0;
      w0 = n_wr;
      g = 0;
      while (n_wr == w0 && g < 200) begin
         @(negedge clk);
         g++;
      end
      check("s4_first_write_seen", 32'(g < 200), 32'(1));
      do_start(13'h777, 1'b0);
      wait_drain();
      check("s4_busy_start_ignored_cnt", 32'(wr_cnt), 32'(2));
      do_start(13'h040, 1'b1);
      check("s4_start_clr_cnt", 32'(wr_cnt), 32'(0));
      check("s4_start_err", 32'(err), 32'(0));
      push_word(32'h5A5A_5A5A);
      valid = 1'b0;
      wait_drain();
      check("s4_wr_cnt", 32'(wr_cnt), 32'(1));

      // reset mid-write with words still buffered
      sink_lat = 100;
      push_word(32'hF000_0000);
      push_word(32'hF000_0001);
      push_word(32'hF000_0002);
      valid = 1'b0;
      repeat (4) @(negedge clk);
      check("s5_trig_before_rst", 32'(trig), 32'(1));
      check("s5_busy_before_rst", 32'(busy), 32'(1));
      #2;
      rstn = 1'b0;
      #1;
      check("s5_rst_trig",   32'(trig),   32'(0));
      check("s5_rst_addr",   32'(baddr),  32'(0));
      check("s5_rst_data",   bdata,       32'(0));
      check("s5_rst_wr_cnt", 32'(wr_cnt), 32'(0));
      check("s5_rst_err",    32'(err),    32'(0));
      check("s5_rst_ready",  32'(ready),  32'(1));
      check("s5_rst_busy",   32'(busy),   32'(0));
      exp_q.delete();
      r0 = n_rise;
      @(negedge clk);
      #2;
      rstn = 1'b1;
      repeat (20) @(negedge clk);
      check("s5_no_write_after_rst", 32'(n_rise), 32'(r0));
      check("s5_idle_after_rst", 32'(busy), 32'(0));
      check("s5_trig_after_rst", 32'(trig), 32'(0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
